// File: rtl/keygen_seq_if.sv
// keygen_seq_if: per-stage request/response handshake channels between sequencer and engines
//   req_valid/req_ready : request handshake, one bit per stage
//   res_valid/res_ready : response handshake, one bit per stage
//   cap                 : result-capture strobe for the parent, mirrors res_ready
interface keygen_seq_if #(parameter int NSTAGE = 4);
    logic [NSTAGE-1:0] req_valid, req_ready, res_valid, res_ready, cap;
    modport master (output req_valid, res_ready, cap, input req_ready, res_valid);
    modport slave (input req_valid, res_ready, cap, output req_ready, res_valid);
endinterface

// File: rtl/keygen_seq.sv
// keygen_seq: runs enabled stage engines in index order, watchdogs each wait, verifies and retries
//   clk, rstn              : clock, asynchronous active-low reset
//   start, stage_en        : run request and stage mask (mask/limit latched on accept)
//   timeout_lim            : watchdog limit in cycles, 0 disables
//   ch                     : stage handshake channels (master side)
//   ref_val, chk_val       : compared in CHECK
//   busy, done, succ, fail : run status
//   err_stage, err_code    : failing stage and cause (1 accept, 2 response, 3 mismatch)
//   retries                : re-runs performed in this run
module keygen_seq #(
    parameter int NSTAGE   = 4,
    parameter int TW       = 16,
    parameter int MAXRETRY = 3,
    parameter int W        = 128
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [NSTAGE-1:0] stage_en,
    input  logic [TW-1:0]     timeout_lim,
    keygen_seq_if.master      ch,
    input  logic [W-1:0]      ref_val,
    input  logic [W-1:0]      chk_val,
    output logic              busy,
    output logic              done,
    output logic              succ,
    output logic              fail,
    output logic [2:0]        err_stage,
    output logic [1:0]        err_code,
    output logic [3:0]        retries
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, ACK, CHECK, DONE} state_t;
    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d, err_stage_q, err_stage_d;
    logic [NSTAGE-1:0] mask_q, mask_d, req_valid_q, req_valid_d, res_ready_q, res_ready_d, cur;
    logic [TW-1:0]     lim_q, lim_d, cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d, succ_q, succ_d, fail_q, fail_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [3:0]        retries_q, retries_d, nx;
    logic              hit, launch;
    int                from;

    // lowest enabled stage at or above lo; bit 3 flags that one exists
    function automatic logic [3:0] pick(input logic [NSTAGE-1:0] m, input int lo);
        pick = '0;
        for (int j = NSTAGE - 1; j >= 0; j--)
            if (m[j] && j >= lo) pick = {1'b1, 3'(j)};
    endfunction

    assign cur = NSTAGE'(1) << idx_q;
    // fires on the L-th cycle in REQ/WAIT so DONE follows exactly L cycles after entry
    assign hit = lim_q != '0 && cnt_q == lim_q - TW'(1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        lim_d       = lim_q;
        cnt_d       = cnt_q + TW'(1);
        req_valid_d = '0;
        res_ready_d = '0;
        busy_d      = busy_q;
        done_d      = done_q;
        succ_d      = succ_q;
        fail_d      = fail_q;
        err_stage_d = err_stage_q;
        err_code_d  = err_code_q;
        retries_d   = retries_q;
        launch      = 1'b0;
        from        = 0;
        case (state_q)
            IDLE, DONE: if (start) begin
                mask_d      = stage_en;
                lim_d       = timeout_lim;
                retries_d   = '0;
                done_d      = 1'b0;
                succ_d      = 1'b0;
                fail_d      = 1'b0;
                err_stage_d = '0;
                err_code_d  = '0;
                busy_d      = 1'b1;
                launch      = 1'b1;
            end
            // a handshake beats a watchdog hit in the same cycle
            REQ: if (|(ch.req_ready & cur)) begin
                state_d = WAIT;
                cnt_d   = '0;
            end else if (hit) begin
                state_d     = DONE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                fail_d      = 1'b1;
                err_stage_d = idx_q;
                err_code_d  = 2'd1;
            end else req_valid_d = req_valid_q;
            WAIT: if (|(ch.res_valid & cur)) begin
                state_d     = ACK;
                res_ready_d = cur;
            end else if (hit) begin
                state_d     = DONE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                fail_d      = 1'b1;
                err_stage_d = idx_q;
                err_code_d  = 2'd2;
            end
            ACK: begin
                launch = 1'b1;
                from   = int'(idx_q) + 1;
            end
            CHECK: if (chk_val == ref_val) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                succ_d  = 1'b1;
            end else if (retries_q < 4'(MAXRETRY)) begin
                retries_d = retries_q + 4'd1;
                launch    = 1'b1;
            end else begin
                state_d     = DONE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                fail_d      = 1'b1;
                err_stage_d = 3'(NSTAGE - 1);
                err_code_d  = 2'd3;
            end
            default: state_d = IDLE;
        endcase
        // shared launch into the next enabled stage, or CHECK when none remain
        nx = pick(mask_d, from);
        if (launch) begin
            state_d     = nx[3] ? REQ : CHECK;
            idx_d       = nx[2:0];
            req_valid_d = nx[3] ? NSTAGE'(1) << nx[2:0] : '0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            mask_q      <= '0;
            lim_q       <= '0;
            cnt_q       <= '0;
            req_valid_q <= '0;
            res_ready_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            succ_q      <= 1'b0;
            fail_q      <= 1'b0;
            err_stage_q <= '0;
            err_code_q  <= '0;
            retries_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            lim_q       <= lim_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            res_ready_q <= res_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            succ_q      <= succ_d;
            fail_q      <= fail_d;
            err_stage_q <= err_stage_d;
            err_code_q  <= err_code_d;
            retries_q   <= retries_d;
        end
    end

    assign ch.req_valid = req_valid_q;
    assign ch.res_ready = res_ready_q;
    assign ch.cap       = res_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign succ         = succ_q;
    assign fail         = fail_q;
    assign err_stage    = err_stage_q;
    assign err_code     = err_code_q;
    assign retries      = retries_q;
endmodule

// File: tb/tb_keygen_seq.sv
// tb_keygen_seq: randomized engine responders checked against a cycle-accounting run model
module tb_keygen_seq;
    localparam int N = 4, TW = 16, MR = 3, W = 128;
    logic          clk = 1'b0, rstn = 1'b0, start = 1'b0;
    logic [N-1:0]  stage_en = '0;
    logic [TW-1:0] timeout_lim = '0;
    logic [W-1:0]  ref_val = '0, chk_val = '0;
    logic          busy, done, succ, fail;
    logic [2:0]    err_stage;
    logic [1:0]    err_code;
    logic [3:0]    retries;
    keygen_seq_if #(.NSTAGE(N)) ch();

    keygen_seq #(.NSTAGE(N), .TW(TW), .MAXRETRY(MR), .W(W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .stage_en(stage_en), .timeout_lim(timeout_lim),
        .ch(ch), .ref_val(ref_val), .chk_val(chk_val), .busy(busy), .done(done), .succ(succ),
        .fail(fail), .err_stage(err_stage), .err_code(err_code), .retries(retries)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_err = 0;
    int dr[N], dv[N];
    int e_done, e_succ, e_fail, e_code, e_stage, e_retries;
    int e_cap[N], e_vc[N], e_rise[N];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, ".stat"}, {busy, done, succ, fail}, 0);
        check({tag, ".err"}, {err_stage, err_code, retries}, 0);
        check({tag, ".ch"}, {ch.req_valid, ch.res_ready, ch.cap}, 0);
    endtask

    // engine i takes dr[i] extra cycles to accept and dv[i] extra cycles to respond;
    // each stage costs (dr+1) + (dv+1) + 1 cycles, CHECK costs one, timeouts cost lim
    function automatic void model(logic [N-1:0] mask, int lim, int nmis);
        int t = 1, pass = 0;
        bit fin = 0;
        e_succ = 0; e_fail = 0; e_code = 0; e_stage = 0; e_retries = 0; e_done = 0;
        for (int i = 0; i < N; i++) begin e_cap[i] = 0; e_vc[i] = 0; e_rise[i] = -1; end
        while (!fin) begin
            for (int i = 0; i < N; i++) begin
                if (!mask[i]) continue;
                if (e_rise[i] < 0) e_rise[i] = t;
                if (lim != 0 && dr[i] >= lim) begin
                    e_vc[i] += lim; e_done = t + lim; e_fail = 1; e_code = 1; e_stage = i; fin = 1;
                    break;
                end
                e_vc[i] += dr[i] + 1;
                t += dr[i] + 1;
                if (lim != 0 && dv[i] >= lim) begin
                    e_done = t + lim; e_fail = 1; e_code = 2; e_stage = i; fin = 1;
                    break;
                end
                t += dv[i] + 2;
                e_cap[i]++;
            end
            if (fin) break;
            if (pass < nmis && e_retries < MR) begin
                e_retries++; pass++; t++;
            end else begin
                e_done = t + 1; fin = 1;
                if (pass < nmis) begin e_fail = 1; e_code = 3; e_stage = N - 1; end
                else e_succ = 1;
            end
        end
    endfunction

    task automatic run(string tag, logic [N-1:0] mask, int lim, int nmis, bit abort);
        int t = 0, passes = 0, viol = 0, last = -1, done_t = -1;
        int rc[N], wc[N], cap_n[N], vc[N], rise[N];
        bit pend[N];
        model(mask, lim, nmis);
        for (int i = 0; i < N; i++) begin
            rc[i] = 0; wc[i] = 0; cap_n[i] = 0; vc[i] = 0; rise[i] = -1; pend[i] = 0;
            if (mask[i]) last = i;
        end
        ch.req_ready = '0;
        ch.res_valid = '0;
        ref_val = {$urandom, $urandom, $urandom, $urandom};
        chk_val = ref_val;
        @(negedge clk);
        start = 1'b1; stage_en = mask; timeout_lim = TW'(lim);
        while (t < 3000) begin
            @(negedge clk);
            t++;
            start = 1'b0;
            stage_en = N'($urandom);
            timeout_lim = TW'($urandom);
            viol += int'($countones(ch.req_valid) > 1) + int'($countones(ch.res_ready) > 1)
                  + int'((ch.req_valid & ~mask) != 0) + int'(ch.cap != ch.res_ready);
            for (int i = 0; i < N; i++) begin
                if (ch.req_valid[i]) begin vc[i]++; if (rise[i] < 0) rise[i] = t; end
                if (ch.cap[i]) begin cap_n[i]++; pend[i] = 0; if (i == last) passes++; end
            end
            if (done) begin done_t = t; break; end
            if (abort && pend[2] && wc[2] == 3) begin
                check({tag, ".busy_pre"}, busy, 1);
                rstn = 1'b0;
                #1;
                check_zero({tag, ".async"});
                #2;
                rstn = 1'b1;
                return;
            end
            for (int i = 0; i < N; i++)
                if (pend[i]) begin wc[i]++; ch.res_valid[i] = wc[i] >= dv[i] + 1; end
                else ch.res_valid[i] = 1'($urandom);
            for (int i = 0; i < N; i++)
                if (ch.req_valid[i]) begin
                    rc[i]++;
                    ch.req_ready[i] = rc[i] >= dr[i] + 1;
                    if (ch.req_ready[i]) begin pend[i] = 1; wc[i] = 0; end
                end else begin
                    rc[i] = 0;
                    ch.req_ready[i] = 1'($urandom);
                end
            chk_val = (passes >= 1 && passes <= nmis) ? ref_val ^ W'(1) : ref_val;
            start = busy && ($urandom % 8 == 0);
        end
        if (done_t < 0) begin
            check({tag, ".hang"}, 0, 1);
            return;
        end
        check({tag, ".done_t"}, done_t, e_done);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".succ"}, succ, e_succ);
        check({tag, ".fail"}, fail, e_fail);
        check({tag, ".code"}, err_code, e_code);
        check({tag, ".stage"}, err_stage, e_stage);
        check({tag, ".retries"}, retries, e_retries);
        check({tag, ".viol"}, viol, 0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s.cap%0d", tag, i), cap_n[i], e_cap[i]);
            check($sformatf("%s.vc%0d", tag, i), vc[i], e_vc[i]);
            check($sformatf("%s.rise%0d", tag, i), rise[i], e_rise[i]);
        end
    endtask

    task automatic set_delays(int a, int b);
        for (int i = 0; i < N; i++) begin dr[i] = a; dv[i] = b; end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;
        set_delays(0, 0);
        run("full", 4'b1111, 0, 0, 0);
        run("mask1010", 4'b1010, 0, 0, 0);
        set_delays(1, 2);
        dr[2] = 100;
        run("req_to", 4'b1111, 20, 0, 0);
        set_delays(0, 1);
        dv[1] = 10;
        run("wait_to", 4'b0111, 5, 0, 0);
        set_delays(0, 0);
        dr[0] = 3; dv[3] = 3;
        run("edge_win", 4'b1001, 4, 0, 0);
        set_delays(1, 0);
        run("retry2", 4'b1111, 0, 2, 0);
        run("retry_max", 4'b0110, 0, 9, 0);
        run("mask0", 4'b0000, 0, 0, 0);
        set_delays(0, 0);
        dv[2] = 50;
        run("abort", 4'b1111, 0, 0, 1);
        check_zero("post_abort");
        set_delays(0, 0);
        run("after_abort", 4'b1111, 0, 0, 0);
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                dr[i] = ($urandom % 10 == 0) ? 12 : $urandom_range(0, 3);
                dv[i] = ($urandom % 10 == 0) ? 12 : $urandom_range(0, 3);
            end
            run($sformatf("rnd%0d", r), N'($urandom_range(1, 15)),
                ($urandom % 3 == 0) ? 0 : $urandom_range(2, 8), $urandom_range(0, 4), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
